// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   AW_DEFAULT   : default memory word-address width (1024 words)
//   BASE_DEFAULT : CPU byte address that maps to data-memory word 0
//   WAIT_W       : width of the SDU anti-starvation counter (covers 1..15)
//   owner_t      : who owns the read data returned by the memory next cycle
package dmem_pkg;

    localparam int          AW_DEFAULT   = 10;
    localparam logic [31:0] BASE_DEFAULT = 32'h0000_2000;
    localparam int          WAIT_W       = 4;

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_CPU     = 2'd1,
        OWN_CPU_ERR = 2'd2,
        OWN_SDU     = 2'd3
    } owner_t;

endpackage

// File: rtl/dmem_addr_xlate.sv
// CPU byte address -> data-memory word index, with range check.
//   cpu_addr : CPU byte address (bits [1:0] ignored)
//   word     : word index relative to BASE (low AW bits of the word offset)
//   in_range : address lies inside [BASE, BASE + 4*2**AW)
module dmem_addr_xlate
    import dmem_pkg::*;
#(
    parameter int          AW   = AW_DEFAULT,
    parameter logic [31:0] BASE = BASE_DEFAULT
) (
    input  logic [31:0]   cpu_addr,
    output logic [AW-1:0] word,
    output logic          in_range
);

    logic [31:0] off;
    logic        unused_byte_bits;

    assign off  = cpu_addr - BASE;
    assign word = off[AW+1:2];
    // Below BASE the subtraction wraps, so the explicit compare is required.
    assign in_range = (cpu_addr >= BASE) && (off[31:AW+2] == '0);
    assign unused_byte_bits = ^off[1:0];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between the CPU load/store path and the
// SDU debug port. Fixed CPU priority, with an SDU anti-starvation counter.
//   clk, rstn                : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata    : CPU request (byte address), held until cpu_gnt
//   cpu_gnt                  : CPU request accepted this cycle (combinational)
//   cpu_rvalid/rdata/err     : CPU load return (or error) one cycle after grant
//   sdu_halt                 : debugger freeze; blocks all CPU grants
//   sdu_req/we/addr/wdata    : SDU request (word index), held until sdu_gnt
//   sdu_gnt                  : SDU request accepted this cycle (combinational)
//   sdu_rvalid/rdata         : SDU read return one cycle after grant
//   mem_a/d/we, mem_q        : memory macro port, 1-cycle read latency
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int          AW         = AW_DEFAULT,
    parameter logic [31:0] BASE       = BASE_DEFAULT,
    parameter int          STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    input  logic          sdu_halt,
    input  logic          sdu_req,
    input  logic          sdu_we,
    input  logic [AW-1:0] sdu_addr,
    input  logic [31:0]   sdu_wdata,
    output logic          sdu_gnt,
    output logic          sdu_rvalid,
    output logic [31:0]   sdu_rdata,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_d,
    output logic          mem_we,
    input  logic [31:0]   mem_q
);

    localparam logic [WAIT_W-1:0] STARVE_LIM = WAIT_W'(STARVE_MAX);

    logic [AW-1:0]     cpu_word;
    logic              cpu_in_range;
    logic              sdu_win;
    logic              cpu_win;
    logic [WAIT_W-1:0] wait_cnt;
    logic [AW-1:0]     last_a_p1;
    owner_t            owner_p0;
    owner_t            owner_p1;

    dmem_addr_xlate #(
        .AW   (AW),
        .BASE (BASE)
    ) u_xlate (
        .cpu_addr (cpu_addr),
        .word     (cpu_word),
        .in_range (cpu_in_range)
    );

    // Stage p0: arbitration and memory drive, all combinational.
    // Grants are masked while reset is asserted so nothing reaches the macro.
    always_comb begin
        sdu_win = rstn && sdu_req &&
                  ((wait_cnt == STARVE_LIM) || !cpu_req || sdu_halt);
        cpu_win = rstn && cpu_req && !sdu_halt && !sdu_win;
    end

    assign sdu_gnt = sdu_win;
    assign cpu_gnt = cpu_win;

    always_comb begin
        mem_a    = last_a_p1;
        mem_d    = '0;
        mem_we   = 1'b0;
        owner_p0 = OWN_NONE;
        if (sdu_win) begin
            mem_a  = sdu_addr;
            mem_d  = sdu_wdata;
            mem_we = sdu_we;
            if (!sdu_we) begin
                owner_p0 = OWN_SDU;
            end
        end else if (cpu_win) begin
            mem_a = cpu_word;
            mem_d = cpu_wdata;
            // Out-of-range accesses never write; they report an error instead.
            if (!cpu_in_range) begin
                owner_p0 = OWN_CPU_ERR;
            end else if (cpu_we) begin
                mem_we = 1'b1;
            end else begin
                owner_p0 = OWN_CPU;
            end
        end
    end

    // Stage p1: owner of next cycle's read data, starvation counter, held address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt  <= '0;
            owner_p1  <= OWN_NONE;
            last_a_p1 <= '0;
        end else begin
            owner_p1  <= owner_p0;
            last_a_p1 <= mem_a;
            if (sdu_req && !sdu_win) begin
                if (wait_cnt != STARVE_LIM) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Return mux: only the owner sees mem_q; everyone else reads zero.
    always_comb begin
        cpu_rvalid = (owner_p1 == OWN_CPU) || (owner_p1 == OWN_CPU_ERR);
        cpu_err    = (owner_p1 == OWN_CPU_ERR);
        cpu_rdata  = (owner_p1 == OWN_CPU) ? mem_q : '0;
        sdu_rvalid = (owner_p1 == OWN_SDU);
        sdu_rdata  = (owner_p1 == OWN_SDU) ? mem_q : '0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int          AW         = 10;
    localparam int          DEPTH      = 1024;
    localparam logic [31:0] BASE       = 32'h0000_2000;
    localparam int          STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cpu_req, cpu_we;
    logic [31:0]   cpu_addr, cpu_wdata;
    logic          cpu_gnt, cpu_rvalid, cpu_err;
    logic [31:0]   cpu_rdata;
    logic          sdu_halt, sdu_req, sdu_we;
    logic [AW-1:0] sdu_addr;
    logic [31:0]   sdu_wdata;
    logic          sdu_gnt, sdu_rvalid;
    logic [31:0]   sdu_rdata;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_d;
    logic          mem_we;
    logic [31:0]   mem_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(AW), .BASE(BASE), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .sdu_halt(sdu_halt), .sdu_req(sdu_req), .sdu_we(sdu_we), .sdu_addr(sdu_addr),
        .sdu_wdata(sdu_wdata), .sdu_gnt(sdu_gnt), .sdu_rvalid(sdu_rvalid), .sdu_rdata(sdu_rdata),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
    );

    // Initial memory image shared by the macro and the reference model.
    function automatic logic [31:0] init_val(int i);
        if (i == 2) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory macro: 1024 x 32, synchronous read, 1-cycle latency.
    logic        init_go;
    logic [31:0] mac [0:DEPTH-1];
    always @(posedge clk) begin
        if (init_go) begin
            for (int i = 0; i < DEPTH; i++) mac[i] <= init_val(i);
        end else if (mem_we) begin
            mac[mem_a] <= mem_d;
        end
        mem_q <= mac[mem_a];
    end

    // Reference model state.
    logic [31:0] ref_mem [0:DEPTH-1];
    int          wcnt;
    int          last_a;
    logic        p_cpu_v, p_cpu_e, p_sdu_v;
    logic [31:0] p_cpu_d, p_sdu_d;

    // Values observed at the most recent cycle() sample point.
    logic        o_cpu_gnt, o_sdu_gnt, o_mem_we, o_cpu_rvalid, o_cpu_err, o_sdu_rvalid;
    logic [31:0] o_cpu_rdata, o_sdu_rdata;
    logic [AW-1:0] o_mem_a;

    task automatic check1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        wcnt = 0; last_a = 0;
        p_cpu_v = 0; p_cpu_e = 0; p_sdu_v = 0; p_cpu_d = '0; p_sdu_d = '0;
    endtask

    // One clock cycle: inputs already applied just after a rising edge.
    task automatic cycle();
        logic        eg_s, eg_c, inr, ewe;
        logic [31:0] off;
        int          word;
        logic        n_cpu_v, n_cpu_e, n_sdu_v;
        logic [31:0] n_cpu_d, n_sdu_d;
        longint      a;

        a    = longint'(cpu_addr);
        inr  = (a >= longint'(BASE)) && ((a - longint'(BASE)) / 4 < DEPTH);
        off  = cpu_addr - BASE;
        word = int'(off / 4) % DEPTH;
        eg_s = sdu_req && (wcnt == STARVE_MAX || !cpu_req || sdu_halt);
        eg_c = cpu_req && !sdu_halt && !eg_s;
        ewe  = eg_s ? sdu_we : (eg_c && cpu_we && inr);

        @(negedge clk);
        o_cpu_gnt = cpu_gnt; o_sdu_gnt = sdu_gnt; o_mem_we = mem_we; o_mem_a = mem_a;
        o_cpu_rvalid = cpu_rvalid; o_cpu_err = cpu_err; o_cpu_rdata = cpu_rdata;
        o_sdu_rvalid = sdu_rvalid; o_sdu_rdata = sdu_rdata;

        check1("cpu_gnt", cpu_gnt, eg_c);
        check1("sdu_gnt", sdu_gnt, eg_s);
        check1("mem_we", mem_we, ewe);
        if (eg_s) begin
            check32("mem_a_sdu", 32'(mem_a), 32'(sdu_addr));
            if (sdu_we) check32("mem_d_sdu", mem_d, sdu_wdata);
        end else if (eg_c) begin
            check32("mem_a_cpu", 32'(mem_a), 32'(word));
            if (cpu_we && inr) check32("mem_d_cpu", mem_d, cpu_wdata);
        end else begin
            check32("mem_a_hold", 32'(mem_a), 32'(last_a));
        end
        check1("cpu_rvalid", cpu_rvalid, p_cpu_v);
        check1("cpu_err", cpu_err, p_cpu_e);
        check32("cpu_rdata", cpu_rdata, p_cpu_d);
        check1("sdu_rvalid", sdu_rvalid, p_sdu_v);
        check32("sdu_rdata", sdu_rdata, p_sdu_d);

        n_cpu_v = 0; n_cpu_e = 0; n_sdu_v = 0; n_cpu_d = '0; n_sdu_d = '0;
        if (eg_s) begin
            last_a = int'(sdu_addr);
            if (sdu_we) ref_mem[sdu_addr] = sdu_wdata;
            else begin n_sdu_v = 1; n_sdu_d = ref_mem[sdu_addr]; end
        end else if (eg_c) begin
            last_a = word;
            if (!inr) begin n_cpu_v = 1; n_cpu_e = 1; end
            else if (cpu_we) ref_mem[word] = cpu_wdata;
            else begin n_cpu_v = 1; n_cpu_d = ref_mem[word]; end
        end
        if (sdu_req && !eg_s) wcnt = (wcnt + 1 > STARVE_MAX) ? STARVE_MAX : wcnt + 1;
        else wcnt = 0;

        @(posedge clk); #1;
        p_cpu_v = n_cpu_v; p_cpu_e = n_cpu_e; p_cpu_d = n_cpu_d;
        p_sdu_v = n_sdu_v; p_sdu_d = n_sdu_d;
    endtask

    task automatic idle();
        cpu_req = 0; sdu_req = 0; sdu_halt = 0; cpu_we = 0; sdu_we = 0;
        cycle();
    endtask

    task automatic cpu_op(logic we, logic [31:0] addr, logic [31:0] wd);
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic sdu_op(logic we, logic [AW-1:0] addr, logic [31:0] wd);
        sdu_req = 1; sdu_we = we; sdu_addr = addr; sdu_wdata = wd;
    endtask

    typedef struct {
        logic          cr, cw;
        logic [31:0]   ca;
        logic          h, sr, sw;
        logic [AW-1:0] sa;
        logic          e_cg, e_sg, e_we, e_err;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    initial begin
        //        cr    cw    ca            h     sr    sw    sa      cg    sg    we    err
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 32'h0000_2FFC, 1'b0, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 32'h0000_1FFC, 1'b0, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_2040, 1'b0, 1'b1, 1'b0, 10'd3,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_2040, 1'b1, 1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 10'd20, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 32'h0000_2044, 1'b1, 1'b1, 1'b0, 10'd20, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_2003, 1'b0, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        rstn = 0; init_go = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        sdu_halt = 0; sdu_req = 0; sdu_we = 0; sdu_addr = '0; sdu_wdata = '0;
        model_clear();

        // Reset state
        @(posedge clk); #1; init_go = 0;
        @(negedge clk);
        check1("rst_cpu_gnt", cpu_gnt, 1'b0);
        check1("rst_sdu_gnt", sdu_gnt, 1'b0);
        check1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check1("rst_cpu_err", cpu_err, 1'b0);
        check1("rst_sdu_rvalid", sdu_rvalid, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check32("rst_mem_a", 32'(mem_a), 32'd0);
        check32("rst_cpu_rdata", cpu_rdata, 32'd0);
        check32("rst_sdu_rdata", sdu_rdata, 32'd0);
        @(posedge clk); #1; rstn = 1;

        // Table-driven single-cycle vectors, each followed by an idle cycle
        for (int i = 0; i < NV; i++) begin
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca;
            cpu_wdata = 32'hA000_0000 + 32'(i);
            sdu_halt = tbl[i].h; sdu_req = tbl[i].sr; sdu_we = tbl[i].sw;
            sdu_addr = tbl[i].sa; sdu_wdata = 32'hB000_0000 + 32'(i);
            cycle();
            check1($sformatf("vec%0d_cpu_gnt", i), o_cpu_gnt, tbl[i].e_cg);
            check1($sformatf("vec%0d_sdu_gnt", i), o_sdu_gnt, tbl[i].e_sg);
            check1($sformatf("vec%0d_mem_we", i), o_mem_we, tbl[i].e_we);
            idle();
            check1($sformatf("vec%0d_cpu_err", i), o_cpu_err, tbl[i].e_err);
        end

        // 1: CPU load from 0x2008
        cpu_op(0, 32'h0000_2008, '0); cycle();
        check1("t1_gnt", o_cpu_gnt, 1'b1);
        check32("t1_mem_a", 32'(o_mem_a), 32'd2);
        idle();
        check1("t1_rvalid", o_cpu_rvalid, 1'b1);
        check32("t1_rdata", o_cpu_rdata, 32'hDEAD_BEEF);

        // 2: out-of-range stores below and above the window
        cpu_op(1, 32'h0000_1FFC, 32'h1111_1111); cycle();
        check1("t2a_gnt", o_cpu_gnt, 1'b1);
        check1("t2a_we", o_mem_we, 1'b0);
        idle();
        check1("t2a_err", o_cpu_err, 1'b1);
        check1("t2a_rvalid", o_cpu_rvalid, 1'b1);
        check32("t2a_rdata", o_cpu_rdata, 32'd0);
        cpu_op(1, 32'h0000_3000, 32'h2222_2222); cycle();
        check1("t2b_gnt", o_cpu_gnt, 1'b1);
        check1("t2b_we", o_mem_we, 1'b0);
        idle();
        check1("t2b_err", o_cpu_err, 1'b1);
        check32("t2b_rdata", o_cpu_rdata, 32'd0);

        // 3: continuous contention, SDU wins on the fifth cycle
        cpu_op(0, 32'h0000_2010, '0); sdu_op(0, 10'd5, '0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check1($sformatf("t3_cpu_gnt%0d", k), o_cpu_gnt, k < 4);
            check1($sformatf("t3_sdu_gnt%0d", k), o_sdu_gnt, k == 4);
        end
        sdu_req = 0; cycle();
        check1("t3_sdu_rvalid", o_sdu_rvalid, 1'b1);
        check1("t3_cpu_gnt_after", o_cpu_gnt, 1'b1);
        idle();

        // 4: halt rising after a granted load, then SDU write under halt
        cpu_op(0, 32'h0000_2000, '0); cycle();
        sdu_halt = 1; sdu_op(1, 10'd7, 32'h1234_5678); cycle();
        check1("t4_inflight_rvalid", o_cpu_rvalid, 1'b1);
        check1("t4_cpu_gnt", o_cpu_gnt, 1'b0);
        check1("t4_sdu_gnt", o_sdu_gnt, 1'b1);
        check1("t4_mem_we", o_mem_we, 1'b1);
        check32("t4_mem_a", 32'(o_mem_a), 32'd7);
        sdu_req = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check1($sformatf("t4_halt_gnt%0d", k), o_cpu_gnt, 1'b0);
        end
        sdu_halt = 0; cycle();
        check1("t4_release_gnt", o_cpu_gnt, 1'b1);
        cpu_req = 0; sdu_op(0, 10'd7, '0); cycle();
        sdu_req = 0; cycle();
        check32("t4_readback", o_sdu_rdata, 32'h1234_5678);

        // 5: alternating CPU / SDU loads with no bubbles
        for (int k = 0; k < 7; k++) begin
            if (k % 2 == 0) begin cpu_op(0, 32'h0000_2004, '0); sdu_req = 0; end
            else begin cpu_req = 0; sdu_op(0, 10'd9, '0); end
            if (k == 6) begin cpu_req = 0; sdu_req = 0; end
            cycle();
            if (k < 6) check1($sformatf("t5_gnt%0d", k), (k % 2 == 0) ? o_cpu_gnt : o_sdu_gnt, 1'b1);
            if (k > 0) begin
                check1($sformatf("t5_cpu_rv%0d", k), o_cpu_rvalid, (k % 2) == 1);
                check1($sformatf("t5_sdu_rv%0d", k), o_sdu_rvalid, (k % 2) == 0);
            end
        end

        // 6: reset the cycle after a granted load
        cpu_op(0, 32'h0000_2008, '0); cycle();
        cpu_req = 0; rstn = 0;
        @(negedge clk);
        check1("t6_cpu_rvalid", cpu_rvalid, 1'b0);
        check1("t6_cpu_err", cpu_err, 1'b0);
        check32("t6_cpu_rdata", cpu_rdata, 32'd0);
        check1("t6_sdu_rvalid", sdu_rvalid, 1'b0);
        check32("t6_mem_a", 32'(mem_a), 32'd0);
        check1("t6_mem_we", mem_we, 1'b0);
        model_clear();
        @(posedge clk); #1; rstn = 1;
        cpu_op(0, 32'h0000_2008, '0); cycle();
        check1("t6_gnt", o_cpu_gnt, 1'b1);
        idle();
        check1("t6_rvalid_after", o_cpu_rvalid, 1'b1);
        check32("t6_rdata_after", o_cpu_rdata, 32'hDEAD_BEEF);

        // Randomized traffic, requests held until granted
        for (int n = 0; n < 400; n++) begin
            if (!(cpu_req && !o_cpu_gnt)) begin
                int r;
                r = $urandom_range(0, 9);
                cpu_req = ($urandom_range(0, 99) < 60);
                cpu_we = $urandom_range(0, 1) == 1;
                cpu_wdata = $urandom;
                if (r < 8) cpu_addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
                else if (r == 8) cpu_addr = BASE - 32'(4 * $urandom_range(1, 4));
                else cpu_addr = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 8));
            end
            if (!(sdu_req && !o_sdu_gnt)) begin
                sdu_req = ($urandom_range(0, 99) < 40);
                sdu_we = $urandom_range(0, 1) == 1;
                sdu_addr = AW'($urandom_range(0, DEPTH - 1));
                sdu_wdata = $urandom;
            end
            sdu_halt = ($urandom_range(0, 9) < 2);
            cycle();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
